mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the single-port data memory (byte/half/word RAM + IO word at 4096).
//  Shares the memory between instruction fetch (port IF, read-only word) and load/store unit (port LS).
//  Registers each accepted request, drives the memory control signals for exactly one ACCESS cycle,
//  and returns captured read data with a per-port response pulse. Rejects misaligned accesses.
// PARAMETERS
//  AW           32  address width
//  DW           32  data width
//  STARVE_LIMIT 4   consecutive lost grant opportunities after which IF overrides LS priority (>=1)
// PORTS
//  clk           in  1   clock, all logic on posedge
//  rst_n         in  1   synchronous reset, active low
//  if_valid      in  1   fetch request valid
//  if_addr       in  AW  fetch byte address (word access, no sign extension)
//  if_ready      out 1   fetch request accepted when if_valid & if_ready at posedge
//  if_resp_valid out 1   one-cycle pulse: resp_data/resp_err belong to IF
//  ls_valid      in  1   LSU request valid
//  ls_addr       in  AW  LSU byte address
//  ls_we         in  1   1 = store, 0 = load
//  ls_wdata      in  DW  store data (right-aligned)
//  ls_wl         in  2   0 byte, 1 half, 2 word (3 treated as word)
//  ls_sext       in  1   sign-extend load result
//  ls_ready      out 1   LSU request accepted when ls_valid & ls_ready at posedge
//  ls_resp_valid out 1   one-cycle pulse: resp_data/resp_err belong to LS
//  resp_data     out DW  captured read data (0 for stores and errors)
//  resp_err      out 1   misaligned access flag, valid with a resp_valid pulse
//  mem_addr      out AW  to memory address
//  mem_wdata     out DW  to memory write data
//  mem_we        out 1   to memory write enable
//  mem_re        out 1   to memory read enable
//  mem_wl        out 2   to memory width select
//  mem_sext      out 1   to memory sign-extend select
//  mem_rdata     in  DW  from memory combinational read data
// BEHAVIOUR
//  - FSM states: IDLE, ACCESS, RESP. IDLE/RESP: accept at most one request; accept -> ACCESS, else -> IDLE.
//    ACCESS -> RESP unconditionally. Throughput: one transaction per 2 cycles back-to-back.
//  - if_ready/ls_ready are combinational. At most one is high, and only in IDLE or RESP, and only toward the
//    arbitration winner. A ready may be high while the corresponding valid is low.
//  - Arbitration: LS wins when both are valid, unless starve_cnt == STARVE_LIMIT; then IF wins.
//  - starve_cnt: saturating counter, width clog2(STARVE_LIMIT+1).
//    Increments in IDLE/RESP when if_valid=1 and IF is not granted.
//    Clears when IF is granted or when if_valid=0.
//  - Accept edge: latch addr, we, wdata, wl, sext and the owner id.
//    IF requests latch as we=0, wl=2, sext=0.
//    err_q = (wl==1 & addr[0]) | (wl>=2 & addr[1:0]!=0).
//  - ACCESS cycle (cycle N+1 after accept edge N):
//    mem_addr/wdata/wl/sext = latched values.
//    mem_re = ~we_q & ~err_q.
//    mem_we = we_q & ~err_q & rst_n.
//    No write reaches memory during reset.
//  - Outside ACCESS: mem_we = mem_re = 0; mem_addr, wdata, wl, sext = 0.
//  - Posedge ending ACCESS: resp_data <= (mem_re ? mem_rdata : 0).
//    IO address 4096 passes through untouched.
//  - RESP cycle (N+2): owner's resp_valid = 1 for exactly one cycle; resp_err = err_q.
//    resp_data holds until the next capture.
//  - Load-to-data latency: 2 cycles from the accept edge. A new request may be accepted in the same RESP cycle.
//  - Reset (rst_n=0 at posedge): state -> IDLE, starve_cnt -> 0, resp_data -> 0.
//    All resp_valid, resp_err and mem_* outputs -> 0. Readies are 0 while rst_n=0.
//  - Reset mid-transaction: the transaction is dropped, with no resp pulse and no memory write.
//    The first accept is possible in the cycle after rst_n returns high.
// TESTING
//  1. RAM word 4 = 0xDEADBEEF; if_valid, if_addr=0x10 in IDLE.
//     -> if_ready=1 in cycle 0; cycle 1: mem_re=1, mem_addr=0x10, mem_wl=2;
//        cycle 2: if_resp_valid=1, resp_data=0xDEADBEEF, resp_err=0.
//  2. if_valid and ls_valid (load 0x20, wl=2) in the same cycle.
//     -> ls_ready=1, if_ready=0; LS responds in cycle 2; IF accepted in cycle 2, IF responds in cycle 4.
//  3. ls_valid held high continuously, if_valid high, STARVE_LIMIT=4.
//     -> LS wins 4 opportunities; the 5th grant goes to IF; starve_cnt returns to 0.
//  4. LS half store, ls_addr=0x21, ls_wdata=0x1234.
//     -> mem_we=0 throughout; ls_resp_valid with resp_err=1, resp_data=0; RAM word 8 unchanged.
//  5. LS word store 0xA5A5A5A5 to 0x30 with rst_n=0 during ACCESS.
//     -> mem_we=0, no resp pulse, RAM word 12 unchanged; ready again in the cycle after rst_n=1.
//  6. LS byte store 0x80 to 0x40, then byte load from 0x40 with ls_sext=1.
//     -> second response resp_data=0xFFFFFF80; with ls_sext=0 -> 0x00000080.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port data memory between instruction fetch (IF, word reads only) and the
//   load/store unit (LS). An accepted request is registered, presented to the memory for exactly
//   one ACCESS cycle, and answered in the following RESP cycle with a one-cycle response pulse on
//   the owning port. Misaligned accesses never reach the memory and answer with resp_err set.
//
// Ports
//   clk, rst_n                     clock (posedge) and synchronous active-low reset
//   if_valid/if_addr/if_ready      fetch request handshake (word read)
//   if_resp_valid                  fetch response pulse
//   ls_valid/ls_addr/ls_we/        LSU request handshake: address, store enable, store data,
//   ls_wdata/ls_wl/ls_sext/          width (0 byte, 1 half, 2/3 word) and load sign-extend
//   ls_ready
//   ls_resp_valid                  LSU response pulse
//   resp_data/resp_err             shared response payload, qualified by either resp pulse
//   mem_addr/mem_wdata/mem_we/     memory-side controls, driven only in the ACCESS cycle
//   mem_re/mem_wl/mem_sext
//   mem_rdata                      combinational read data from the memory

module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          if_valid,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic          if_resp_valid,

    input  logic          ls_valid,
    input  logic [AW-1:0] ls_addr,
    input  logic          ls_we,
    input  logic [DW-1:0] ls_wdata,
    input  logic [1:0]    ls_wl,
    input  logic          ls_sext,
    output logic          ls_ready,
    output logic          ls_resp_valid,

    output logic [DW-1:0] resp_data,
    output logic          resp_err,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic [1:0]    mem_wl,
    output logic          mem_sext,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    // Registered request
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic [1:0]    wl_q;
    logic          sext_q;
    logic          err_q;
    logic          owner_ls_q;

    logic [DW-1:0] resp_data_q;

    // Arbitration and handshake
    logic          can_accept;
    logic          if_prio;
    logic          if_sel;
    logic          if_acc;
    logic          ls_acc;
    logic          accept;

    // Request selected for latching
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_we;
    logic [1:0]    req_wl;
    logic          req_sext;
    logic          req_err;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        can_accept = rst_n & (state_q != StAccess);
        if_prio    = (starve_cnt_q == StarveMax);
        // IF takes the slot when LS is absent or IF has been starved long enough.
        // With neither valid, the ready rests on LS.
        if_sel     = if_valid & (~ls_valid | if_prio);
        if_ready   = can_accept & if_sel;
        ls_ready   = can_accept & ~if_sel;
        if_acc     = if_ready & if_valid;
        ls_acc     = ls_ready & ls_valid;
        accept     = if_acc | ls_acc;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (can_accept) begin
            if (!if_valid || if_acc) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != StarveMax) begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end
        end
    end

    // Fetches are always plain word reads.
    always_comb begin
        if (if_acc) begin
            req_addr  = if_addr;
            req_wdata = '0;
            req_we    = 1'b0;
            req_wl    = 2'd2;
            req_sext  = 1'b0;
        end else begin
            req_addr  = ls_addr;
            req_wdata = ls_wdata;
            req_we    = ls_we;
            req_wl    = ls_wl;
            req_sext  = ls_sext;
        end
        // Width 3 is treated as a word, so wl[1] covers both word encodings.
        req_err = ((req_wl == 2'd1) & req_addr[0]) |
                  (req_wl[1] & (req_addr[1:0] != 2'b00));
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StResp: state_d = accept ? StAccess : StIdle;
            StAccess:       state_d = StResp;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            if (state_q == StAccess) begin
                resp_data_q <= mem_re ? mem_rdata : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            wl_q       <= 2'd0;
            sext_q     <= 1'b0;
            err_q      <= 1'b0;
            owner_ls_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            we_q       <= req_we;
            wl_q       <= req_wl;
            sext_q     <= req_sext;
            err_q      <= req_err;
            owner_ls_q <= ls_acc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_wl        = 2'd0;
        mem_sext      = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        resp_err      = 1'b0;
        if (state_q == StAccess) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_wl    = wl_q;
            mem_sext  = sext_q;
            mem_re    = ~we_q & ~err_q;
            // Reset asserted during ACCESS drops the transaction, so the write is blocked here.
            mem_we    = we_q & ~err_q & rst_n;
        end
        if (state_q == StResp) begin
            if_resp_valid = ~owner_ls_q;
            ls_resp_valid = owner_ls_q;
            resp_err      = err_q;
        end
    end

    assign resp_data = resp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam logic [31:0] IoWord = 32'h5A5A_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_resp_valid;
    logic        ls_valid;
    logic [31:0] ls_addr;
    logic        ls_we;
    logic [31:0] ls_wdata;
    logic [1:0]  ls_wl;
    logic        ls_sext;
    logic        ls_ready;
    logic        ls_resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  mem_wl;
    logic        mem_sext;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW           (32),
        .DW           (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_addr       (if_addr),
        .if_ready      (if_ready),
        .if_resp_valid (if_resp_valid),
        .ls_valid      (ls_valid),
        .ls_addr       (ls_addr),
        .ls_we         (ls_we),
        .ls_wdata      (ls_wdata),
        .ls_wl         (ls_wl),
        .ls_sext       (ls_sext),
        .ls_ready      (ls_ready),
        .ls_resp_valid (ls_resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_wl        (mem_wl),
        .mem_sext      (mem_sext),
        .mem_rdata     (mem_rdata)
    );

    // Memory model: 256-word RAM with byte/half/word access, read-only IO word at 4096.
    logic [31:0] ram [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;
    logic [31:0] rd_word;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_idx] <= pre_data;
        end else if (mem_we && mem_addr != 32'd4096) begin
            case (mem_wl)
                2'd0:    ram[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                2'd1:    ram[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                default: ram[mem_addr[9:2]] <= mem_wdata;
            endcase
        end
    end

    always_comb begin
        rd_word = (mem_addr == 32'd4096) ? IoWord : ram[mem_addr[9:2]];
        rd_b    = rd_word[{mem_addr[1:0], 3'b000} +: 8];
        rd_h    = rd_word[{mem_addr[1], 4'b0000} +: 16];
        case (mem_wl)
            2'd0:    mem_rdata = mem_sext ? {{24{rd_b[7]}}, rd_b} : {24'd0, rd_b};
            2'd1:    mem_rdata = mem_sext ? {{16{rd_h[15]}}, rd_h} : {16'd0, rd_h};
            default: mem_rdata = rd_word;
        endcase
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic ls_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [1:0] wl, input logic sx);
        ls_valid = 1'b1;
        ls_addr  = a;
        ls_we    = we;
        ls_wdata = wd;
        ls_wl    = wl;
        ls_sext  = sx;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_addr  = '0;
        ls_valid = 1'b0;
        ls_addr  = '0;
        ls_we    = 1'b0;
        ls_wdata = '0;
        ls_wl    = 2'd0;
        ls_sext  = 1'b0;
        #1;
        preload(8'd4, 32'hDEAD_BEEF);
        preload(8'd5, 32'hCAFE_F00D);
        preload(8'd8, 32'h1122_3344);
        preload(8'd12, 32'h0000_0000);
        preload(8'd16, 32'h0000_0000);

        // Reset state; readies held low while rst_n=0 even with a valid request
        if_valid = 1'b1;
        if_addr  = 32'h10;
        #1;
        chk1("rst_if_ready", if_ready, 1'b0);
        chk1("rst_ls_ready", ls_ready, 1'b0);
        chk1("rst_mem_re", mem_re, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_if_resp", if_resp_valid, 1'b0);
        chk32("rst_resp_data", resp_data, 32'h0);

        // 1: single fetch
        rst_n = 1'b1;
        #1;
        chk1("t1_if_ready", if_ready, 1'b1);
        chk1("t1_ls_ready", ls_ready, 1'b0);
        tick();
        if_valid = 1'b0;
        #1;
        chk1("t1_mem_re", mem_re, 1'b1);
        chk32("t1_mem_addr", mem_addr, 32'h10);
        chk32("t1_mem_wl", {30'd0, mem_wl}, 32'd2);
        chk1("t1_access_if_ready", if_ready, 1'b0);
        tick();
        chk1("t1_if_resp", if_resp_valid, 1'b1);
        chk1("t1_ls_resp", ls_resp_valid, 1'b0);
        chk32("t1_resp_data", resp_data, 32'hDEAD_BEEF);
        chk1("t1_resp_err", resp_err, 1'b0);
        tick();
        chk1("t1_pulse_end", if_resp_valid, 1'b0);
        chk32("t1_data_hold", resp_data, 32'hDEAD_BEEF);

        // 2: simultaneous requests, LS first, IF accepted in LS's RESP cycle
        if_valid = 1'b1;
        if_addr  = 32'h14;
        ls_req(32'h20, 1'b0, 32'h0, 2'd2, 1'b0);
        #1;
        chk1("t2_ls_ready", ls_ready, 1'b1);
        chk1("t2_if_ready", if_ready, 1'b0);
        tick();
        ls_valid = 1'b0;
        #1;
        chk32("t2_mem_addr_ls", mem_addr, 32'h20);
        tick();
        chk1("t2_ls_resp", ls_resp_valid, 1'b1);
        chk32("t2_ls_data", resp_data, 32'h1122_3344);
        chk1("t2_if_ready_resp", if_ready, 1'b1);
        tick();
        if_valid = 1'b0;
        #1;
        chk32("t2_mem_addr_if", mem_addr, 32'h14);
        tick();
        chk1("t2_if_resp", if_resp_valid, 1'b1);
        chk32("t2_if_data", resp_data, 32'hCAFE_F00D);
        tick();

        // 3: starvation override; LS wins 4 times, IF the 5th, LS again after
        if_valid = 1'b1;
        if_addr  = 32'h10;
        ls_req(32'h20, 1'b0, 32'h0, 2'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i > 0) begin
                chk1("t3_ls_resp", ls_resp_valid, (i - 1) != 4);
                chk1("t3_if_resp", if_resp_valid, (i - 1) == 4);
                chk32("t3_resp_data", resp_data,
                      ((i - 1) == 4) ? 32'hDEAD_BEEF : 32'h1122_3344);
            end
            chk1("t3_ls_ready", ls_ready, i != 4);
            chk1("t3_if_ready", if_ready, i == 4);
            tick();
            if (i == 5) begin
                ls_valid = 1'b0;
                if_valid = 1'b0;
            end
            tick();
        end
        chk1("t3_last_ls_resp", ls_resp_valid, 1'b1);
        tick();

        // 4: misaligned half store is rejected
        ls_req(32'h21, 1'b1, 32'h1234, 2'd1, 1'b0);
        #1;
        chk1("t4_ls_ready", ls_ready, 1'b1);
        tick();
        ls_valid = 1'b0;
        #1;
        chk1("t4_mem_we", mem_we, 1'b0);
        chk1("t4_mem_re", mem_re, 1'b0);
        tick();
        chk1("t4_ls_resp", ls_resp_valid, 1'b1);
        chk1("t4_resp_err", resp_err, 1'b1);
        chk32("t4_resp_data", resp_data, 32'h0);
        chk1("t4_mem_we_resp", mem_we, 1'b0);
        tick();
        chk32("t4_ram8", ram[8], 32'h1122_3344);

        // 5: reset during ACCESS of a word store
        ls_req(32'h30, 1'b1, 32'hA5A5_A5A5, 2'd2, 1'b0);
        #1;
        chk1("t5_ls_ready", ls_ready, 1'b1);
        tick();
        ls_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk1("t5_mem_we_rst", mem_we, 1'b0);
        tick();
        chk1("t5_no_resp", ls_resp_valid, 1'b0);
        chk1("t5_mem_we_after", mem_we, 1'b0);
        rst_n = 1'b1;
        ls_req(32'h30, 1'b0, 32'h0, 2'd2, 1'b0);
        #1;
        chk1("t5_ready_after_rst", ls_ready, 1'b1);
        tick();
        ls_valid = 1'b0;
        tick();
        chk1("t5_load_resp", ls_resp_valid, 1'b1);
        chk32("t5_load_data", resp_data, 32'h0);
        chk32("t5_ram12", ram[12], 32'h0);
        tick();

        // 6: byte store then sign-extended and zero-extended byte loads
        ls_req(32'h40, 1'b1, 32'h80, 2'd0, 1'b0);
        #1;
        chk1("t6_st_ready", ls_ready, 1'b1);
        tick();
        ls_valid = 1'b0;
        #1;
        chk1("t6_mem_we", mem_we, 1'b1);
        chk32("t6_mem_wdata", mem_wdata, 32'h80);
        tick();
        ls_req(32'h40, 1'b0, 32'h0, 2'd0, 1'b1);
        #1;
        chk1("t6_st_resp", ls_resp_valid, 1'b1);
        chk1("t6_st_err", resp_err, 1'b0);
        chk1("t6_ld_ready_in_resp", ls_ready, 1'b1);
        tick();
        ls_sext = 1'b0;
        #1;
        chk1("t6_mem_re", mem_re, 1'b1);
        chk1("t6_mem_sext", mem_sext, 1'b1);
        tick();
        chk1("t6_ld_resp", ls_resp_valid, 1'b1);
        chk32("t6_sext_data", resp_data, 32'hFFFF_FF80);
        tick();
        ls_valid = 1'b0;
        #1;
        chk1("t6_mem_sext0", mem_sext, 1'b0);
        tick();
        chk32("t6_zext_data", resp_data, 32'h0000_0080);
        tick();

        // IO word read passes through
        ls_req(32'd4096, 1'b0, 32'h0, 2'd2, 1'b0);
        tick();
        ls_valid = 1'b0;
        tick();
        chk32("io_data", resp_data, IoWord);
        tick();

        // Misaligned fetch
        if_valid = 1'b1;
        if_addr  = 32'h12;
        tick();
        if_valid = 1'b0;
        #1;
        chk1("mis_if_mem_re", mem_re, 1'b0);
        tick();
        chk1("mis_if_resp", if_resp_valid, 1'b1);
        chk1("mis_if_err", resp_err, 1'b1);
        chk32("mis_if_data", resp_data, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
